// File: rtl/pipe_fetch.sv
// -----------------------------------------------------------------------------
// pipe_fetch -- fetch stage and decode-stage pipeline register of a Y86-64
// style pipelined processor.
//
// Each cycle the fetch PC (f_pc) is chosen with redirects taking precedence
// over the predicted PC. The instruction bytes at f_pc are split into fields,
// the instruction length and fall-through PC are computed, a status code is
// assigned, and the next PC is predicted: jumps and calls predict their
// target, everything else predicts the fall-through.
//
// Parameters
//   ADDR_W     PC/address width (valC, valP, PCs)
//   RESET_PC   predicted PC after reset
//   IMEM_SIZE  instruction memory size in bytes (fetches past it fault)
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   F_stall               hold f_predPC (overridden by a redirect)
//   D_stall, D_bubble     hold / squash the decode register (hold wins)
//   mispredict, mis_pc    redirect for a wrongly taken conditional jump
//   ret_done, ret_pc      redirect to a return address from write-back
//   imem_addr             current fetch PC
//   imem_bytes, imem_err  bytes pc..pc+9 (byte 0 in [7:0]) and memory fault
//   D_stat .. D_valP      decode-stage register
//   f_predPC              predicted-PC register
//   halted                fetch frozen after a non-AOK status reached decode
// -----------------------------------------------------------------------------
module pipe_fetch #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                IMEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic              mispredict,
  input  logic [ADDR_W-1:0] mis_pc,
  input  logic              ret_done,
  input  logic [ADDR_W-1:0] ret_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [79:0]       imem_bytes,
  input  logic              imem_err,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [ADDR_W-1:0] D_valC,
  output logic [ADDR_W-1:0] D_valP,
  output logic [ADDR_W-1:0] f_predPC,
  output logic              halted
);

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] REG_NONE   = 4'hF;

  logic [ADDR_W-1:0] f_pc;
  logic [3:0]        f_icode, f_ifun, f_rA, f_rB;
  logic              need_regids, need_valC, instr_valid;
  logic [3:0]        f_len;
  logic [63:0]       const_raw;
  logic [ADDR_W-1:0] f_valC, f_valP, pred_next;
  logic [ADDR_W:0]   end_addr;
  stat_e             f_stat;
  logic              bubble_sel, load_fetch, load_pred;

  // Fetch PC: a mispredict squashes everything younger, including a return.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    f_pc = f_predPC;
    if (mispredict)    f_pc = mis_pc;
    else if (ret_done) f_pc = ret_pc;
  end

  assign imem_addr = f_pc;

  // Field split and instruction length. Invalid opcodes have neither a
  // register byte nor a constant, so they occupy one byte.
  always_comb begin
    f_icode     = imem_bytes[7:4];
    f_ifun      = imem_bytes[3:0];
    need_regids = 1'b0;
    need_valC   = 1'b0;
    instr_valid = 1'b1;
    case (f_icode)
      4'h0, 4'h1, 4'h9:       ;
      4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      4'h7, 4'h8:             need_valC   = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      default:                instr_valid = 1'b0;
    endcase

    f_len = 4'd1 + (need_regids ? 4'd1 : 4'd0) + (need_valC ? 4'd8 : 4'd0);

    f_rA      = need_regids ? imem_bytes[15:12] : REG_NONE;
    f_rB      = need_regids ? imem_bytes[11:8]  : REG_NONE;
    const_raw = need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
    f_valC    = need_valC ? ADDR_W'(const_raw) : '0;
    f_valP    = f_pc + ADDR_W'(f_len);

    // The bounds check uses one extra bit so a PC near the top of the address
    // space cannot wrap around and look in-range.
    end_addr  = {1'b0, f_pc} + (ADDR_W + 1)'(f_len);

    if (imem_err || end_addr > (ADDR_W + 1)'(IMEM_SIZE)) f_stat = STAT_ADR;
    else if (!instr_valid)                             f_stat = STAT_INS;
    else if (f_icode == ICODE_HALT)                    f_stat = STAT_HLT;
    else                                               f_stat = STAT_AOK;

    pred_next = (f_icode == ICODE_JXX || f_icode == ICODE_CALL) ? f_valC : f_valP;
  end

  // While halted, decode is fed bubbles; a mispredict lets the redirected
  // fetch through because the faulting instruction was on the wrong path.
  assign bubble_sel = D_bubble || (halted && !mispredict);
  assign load_fetch = !D_stall && !bubble_sel;
  assign load_pred  = mispredict || ret_done || (!F_stall && !halted);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      f_predPC <= RESET_PC;
      halted   <= 1'b0;
      D_stat   <= STAT_AOK;
      D_icode  <= ICODE_NOP;
      D_ifun   <= 4'h0;
      D_rA     <= REG_NONE;
      D_rB     <= REG_NONE;
      D_valC   <= '0;
      D_valP   <= '0;
    end else begin
      if (load_pred) f_predPC <= pred_next;

      // A faulting instruction reaching decode freezes fetch, even on the
      // cycle of a redirect, since that fault is on the corrected path.
      if (load_fetch && f_stat != STAT_AOK) halted <= 1'b1;
      else if (mispredict)                  halted <= 1'b0;

      if (!D_stall) begin
        if (bubble_sel) begin
          D_stat  <= STAT_AOK;
          D_icode <= ICODE_NOP;
          D_ifun  <= 4'h0;
          D_rA    <= REG_NONE;
          D_rB    <= REG_NONE;
          D_valC  <= '0;
          D_valP  <= '0;
        end else begin
          D_stat  <= f_stat;
          D_icode <= f_icode;
          D_ifun  <= f_ifun;
          D_rA    <= f_rA;
          D_rB    <= f_rB;
          D_valC  <= f_valC;
          D_valP  <= f_valP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch -- self-checking bench for pipe_fetch.
//
// A behavioural model decodes each fetched instruction from a length table and
// tracks the predicted PC, the halted flag and the decode register. Directed
// scenarios are followed by randomized control and instruction stimulus.
// -----------------------------------------------------------------------------
module tb_pipe_fetch;

  localparam int          ADDR_W    = 64;
  localparam int          IMEM_SIZE = 1024;
  localparam logic [63:0] RESET_PC  = 64'h0;

  logic        clk = 1'b0;
  logic        reset, F_stall, D_stall, D_bubble, mispredict, ret_done, imem_err;
  logic [63:0] mis_pc, ret_pc, imem_addr, D_valC, D_valP, f_predPC;
  logic [79:0] imem_bytes;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  pipe_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .IMEM_SIZE(IMEM_SIZE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .F_stall   (F_stall),
    .D_stall   (D_stall),
    .D_bubble  (D_bubble),
    .mispredict(mispredict),
    .mis_pc    (mis_pc),
    .ret_done  (ret_done),
    .ret_pc    (ret_pc),
    .imem_addr (imem_addr),
    .imem_bytes(imem_bytes),
    .imem_err  (imem_err),
    .D_stat    (D_stat),
    .D_icode   (D_icode),
    .D_ifun    (D_ifun),
    .D_rA      (D_rA),
    .D_rB      (D_rB),
    .D_valC    (D_valC),
    .D_valP    (D_valP),
    .f_predPC  (f_predPC),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pred;
  } fetch_t;

  // Model state
  logic [63:0] m_pred;
  logic        m_halted;
  fetch_t      m_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic fetch_t bubble();
    fetch_t b;
    b.stat = 3'd1; b.icode = 4'h1; b.ifun = 4'h0; b.rA = 4'hF; b.rB = 4'hF;
    b.valC = '0;   b.valP = '0;    b.pred = '0;
    return b;
  endfunction

  // Reference decode: instruction length by opcode; the register byte exists
  // for lengths 2 and 10, the 8-byte constant for lengths 9 and 10.
  function automatic fetch_t model_fetch(input logic [63:0] pc, input logic [79:0] b,
                                         input logic err);
    int          len_tab[16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    fetch_t      f;
    int          len, off;
    logic [64:0] end_addr;
    f.icode = b[7:4];
    f.ifun  = b[3:0];
    len     = len_tab[f.icode];
    if (len == 2 || len == 10) begin
      f.rA = b[15:12]; f.rB = b[11:8]; off = 2;
    end else begin
      f.rA = 4'hF;     f.rB = 4'hF;    off = 1;
    end
    f.valC = '0;
    if (len >= 9)
      for (int k = 0; k < 8; k++) f.valC[8*k +: 8] = b[8*(off+k) +: 8];
    f.valP   = pc + 64'(len);
    end_addr = {1'b0, pc} + 65'(len);
    if (err || end_addr > 65'(IMEM_SIZE)) f.stat = 3'd3;
    else if (f.icode > 4'hB)              f.stat = 3'd4;
    else if (f.icode == 4'h0)             f.stat = 3'd2;
    else                                  f.stat = 3'd1;
    f.pred = (f.icode == 4'h7 || f.icode == 4'h8) ? f.valC : f.valP;
    return f;
  endfunction

  // One clock: check the combinational fetch PC, clock, advance the model,
  // then check every registered output.
  task automatic step();
    fetch_t      f;
    logic [63:0] pc;
    logic        old_h, set_h;
    pc = mispredict ? mis_pc : (ret_done ? ret_pc : m_pred);
    #1;
    if (!reset) check("imem_addr", imem_addr, pc);
    f = model_fetch(pc, imem_bytes, imem_err);
    @(posedge clk);
    if (reset) begin
      m_pred   = RESET_PC;
      m_halted = 1'b0;
      m_d      = bubble();
    end else begin
      old_h = m_halted;
      set_h = 1'b0;
      if (mispredict || ret_done || (!F_stall && !old_h)) m_pred = f.pred;
      if (!D_stall) begin
        if (D_bubble || (old_h && !mispredict)) m_d = bubble();
        else begin
          m_d   = f;
          set_h = (f.stat != 3'd1);
        end
      end
      m_halted = set_h ? 1'b1 : (mispredict ? 1'b0 : old_h);
    end
    #1;
    check("D_stat",   D_stat,   m_d.stat);
    check("D_icode",  D_icode,  m_d.icode);
    check("D_ifun",   D_ifun,   m_d.ifun);
    check("D_rA",     D_rA,     m_d.rA);
    check("D_rB",     D_rB,     m_d.rB);
    check("D_valC",   D_valC,   m_d.valC);
    check("D_valP",   D_valP,   m_d.valP);
    check("halted",   halted,   m_halted);
    check("f_predPC", f_predPC, m_pred);
  endtask

  task automatic idle_ctl();
    reset = 0; F_stall = 0; D_stall = 0; D_bubble = 0;
    mispredict = 0; ret_done = 0; imem_err = 0;
  endtask

  function automatic logic [79:0] irmovq(input logic [3:0] rb, input logic [63:0] c);
    return {c, 4'hF, rb, 8'h30};
  endfunction

  localparam logic [79:0] NOP = 80'h10;

  task automatic random_cycle();
    logic [3:0]  icode;
    logic [63:0] c;
    int          r;
    reset      = ($urandom_range(0, 99) < 2);
    F_stall    = ($urandom_range(0, 99) < 20);
    D_stall    = ($urandom_range(0, 99) < 15);
    D_bubble   = ($urandom_range(0, 99) < 15);
    mispredict = ($urandom_range(0, 99) < (m_halted ? 35 : 10));
    ret_done   = ($urandom_range(0, 99) < 8);
    mis_pc     = 64'($urandom_range(0, 1100));
    ret_pc     = 64'($urandom_range(0, 1100));
    imem_err   = ($urandom_range(0, 99) < 3);
    r = $urandom_range(0, 99);
    if (r < 3)      icode = 4'h0;
    else if (r < 8) icode = 4'($urandom_range(12, 15));
    else            icode = 4'($urandom_range(1, 11));
    c = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 1100))
                                    : {32'($urandom), 32'($urandom)};
    imem_bytes = {16'($urandom), 32'($urandom), 32'($urandom)};
    imem_bytes[7:0] = {icode, 4'($urandom_range(0, 15))};
    if (icode >= 4'h3 && icode <= 4'h5)      imem_bytes[79:16] = c;
    else if (icode == 4'h7 || icode == 4'h8) imem_bytes[71:8]  = c;
    step();
  endtask

  initial begin
    idle_ctl();
    mis_pc = '0; ret_pc = '0; imem_bytes = NOP;
    m_pred = RESET_PC; m_halted = 1'b0; m_d = bubble();

    // Reset: bubble in decode, predicted PC at RESET_PC, not halted.
    reset = 1; imem_bytes = {80{1'b1}};
    step(); step();
    check("rst_stat", D_stat, 3'd1);
    check("rst_pred", f_predPC, RESET_PC);
    check("rst_halt", halted, 1'b0);

    // irmovq $0x40, %rbx at pc 0.
    idle_ctl(); imem_bytes = irmovq(4'h3, 64'h40);
    step();
    check("irm_icode", D_icode, 4'h3);
    check("irm_rA",    D_rA,    4'hF);
    check("irm_valC",  D_valC,  64'h40);
    check("irm_valP",  D_valP,  64'hA);
    check("irm_pred",  f_predPC, 64'hA);

    // jXX 0x100 at pc 0x20, then a mispredict to 0x29 under F_stall.
    mispredict = 1; mis_pc = 64'h20; imem_bytes = {8'h00, 64'h100, 8'h70};
    step();
    check("jxx_valP", D_valP,   64'h29);
    check("jxx_pred", f_predPC, 64'h100);
    mis_pc = 64'h29; F_stall = 1; imem_bytes = NOP;
    step();
    check("mis_pred", f_predPC, 64'h2A);

    // Invalid opcode at pc 4 halts; redirect resumes fetch.
    idle_ctl(); mispredict = 1; mis_pc = 64'h4; imem_bytes = 80'hC0;
    step();
    check("ins_stat", D_stat, 3'd4);
    check("ins_halt", halted, 1'b1);
    idle_ctl(); imem_bytes = irmovq(4'h2, 64'h7);
    step(); step();
    check("halt_bub", D_icode, 4'h1);
    check("halt_frz", f_predPC, 64'h5);
    mispredict = 1; mis_pc = 64'h30; imem_bytes = NOP;
    step();
    check("res_halt", halted, 1'b0);
    check("res_valP", D_valP, 64'h31);
    idle_ctl();
    step();

    // Memory bounds: 10-byte instruction ending exactly at, then past, the end.
    mispredict = 1; mis_pc = 64'h3F6; imem_bytes = irmovq(4'h1, 64'h5);
    step();
    check("bnd_edge", D_stat, 3'd1);
    mis_pc = 64'h3FC;
    step();
    check("bnd_over", D_stat, 3'd3);
    imem_bytes = NOP;
    step();
    check("bnd_nop", D_stat, 3'd1);
    imem_err = 1;
    step();
    check("bnd_err", D_stat, 3'd3);
    idle_ctl(); mispredict = 1; mis_pc = 64'h40; imem_bytes = NOP;
    step();

    // Hold beats bubble; F_stall alone freezes only the predicted PC.
    idle_ctl(); D_stall = 1; D_bubble = 1; imem_bytes = irmovq(4'h6, 64'h99);
    step(); step();
    check("hold_valP", D_valP, 64'h41);
    idle_ctl(); F_stall = 1;
    step();
    check("fst_icode", D_icode, 4'h3);

    // Reset in the middle of a stall and a redirect.
    reset = 1; mispredict = 1; mis_pc = 64'h200;
    step();
    check("mid_rst", f_predPC, RESET_PC);

    idle_ctl();
    for (int i = 0; i < 600; i++) random_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
